conv4_window_feeder: RTL and testbench
======================================

// Module: conv4_window_feeder
// PURPOSE
//  Upstream feeder for the layer-2 4x4 fp16 convolution engine. Takes one serial word stream:
//  kernel (row-major), then one feature map (row-major). Drives the engine's row inputs:
//  row vector, kernel_load, valid_in, valid_out. Tags each result with its (row, col) position.
//  Stores the map in KERNEL_SIZE column-interleaved banks and scans vertical strips.
// PARAMETERS
//  DATA_WIDTH   16  word width (fp16, opaque here)
//  KERNEL_SIZE  4   window edge; words per emitted row vector
//  IMG_W        12  feature-map width
//  IMG_H        12  feature-map height
// PORTS
//  clk            in   1               clock
//  rst            in   1               synchronous active-high reset
//  start          in   1               begin a frame; honoured only in IDLE
//  s_data         in   DATA_WIDTH      stream word
//  s_valid        in   1               stream word valid
//  s_ready        out  1               stream word accepted when s_valid & s_ready
//  conv_data      out  DATA_WIDTH x K  row vector; [0] = leftmost column
//  conv_kload     out  1               vector is a kernel row
//  conv_valid_in  out  1               vector valid; engine shifts on this cycle
//  conv_valid_out out  1               engine latches its result register this cycle
//  win_row        out  $clog2(IMG_H)   output row of the result flagged by conv_valid_out
//  win_col        out  $clog2(IMG_W)   output column of the result flagged by conv_valid_out
//  busy           out  1               high in every state except IDLE
//  done           out  1               1-cycle pulse after the last conv_valid_out of a frame
//  err            out  1               sticky overrun flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset
//   - All outputs 0; FSM -> IDLE. Counters cleared. Bank contents are not cleared.
//   - Reset mid-frame aborts the frame immediately. No done pulse.
//  FSM
//   - IDLE -start-> KLOAD -(K*K words)-> ILOAD -(IMG_W*IMG_H words)-> SCAN -(last feed)-> DONE -> IDLE
//  s_ready
//   - High in KLOAD and ILOAD only. A stalled s_valid only pauses the current state.
//  KLOAD
//   - Words assemble into a row register.
//   - The cycle after row r completes: conv_kload=1 and conv_valid_in=1 for 1 cycle, with conv_data = that row.
//   - Exactly K such cycles per frame.
//  ILOAD
//   - Pixel (y,x) goes to bank x%K at address y*ceil(IMG_W/K)+x/K.
//   - No outputs toggle during ILOAD.
//  SCAN
//   - Strips c = 0..IMG_W-K. Each strip has feeds n = 1..IMG_H+1, one per cycle, with no bubbles.
//   - Feed n<=IMG_H: conv_data = pixels (n-1, c..c+K-1), rotated out of the banks. Bank read is registered (1 cycle).
//   - Feed n=IMG_H+1: flush vector, all zeros.
//   - conv_valid_in=1 and conv_kload=0 on every feed.
//   - conv_valid_out=1 in the cycle after feed n, for n = K+1..IMG_H+1.
//   - In those cycles: win_row = n-K-1 and win_col = c. Otherwise win_* hold their last value.
//  Counts
//   - Per frame: (IMG_W-K+1)*(IMG_H+1) feeds.
//   - Per frame: (IMG_W-K+1)*(IMG_H-K+1) conv_valid_out pulses. Defaults give 117 feeds and 81 pulses.
//  DONE
//   - done=1 for one cycle, 1 cycle after the final conv_valid_out. Then IDLE.
//  start
//   - Ignored outside IDLE. A start in the same cycle as the DONE->IDLE transition is ignored.
// CONFIGURATION
//  - CONV4_FEEDER_OVERRUN_CHK_EN defined: err is set when start=1 while busy=1. Cleared only by rst.
//  - Undefined: err is tied to 0. Extra starts are silently ignored in both builds.
// TESTING
//  1. Kernel all 16'h3C00, image all 16'h3C00.
//     -> 4 kload cycles, 117 feeds, 81 valid_out, engine outputs all 16'h4C00.
//  2. Pixel (y,x) = y*16+x, strip c=2, feed n=4.
//     -> conv_data = {0x32,0x33,0x34,0x35} for [0..3]. Flush feed is all 0.
//  3. Check valid_out/tag sequence.
//     -> first valid_out 1 cycle after feed 5 of strip 0, (row,col)=(0,0).
//     -> last is (8,8). done 1 cycle later.
//  4. s_valid toggled every other cycle.
//     -> KLOAD+ILOAD take 320 cycles. Vectors and results identical to test 1.
//  5. rst asserted during SCAN strip 4.
//     -> next cycle all outputs 0, s_ready 0, busy 0, no done.
//     -> a new full frame then matches test 1.
//  6. start pulsed during ILOAD.
//     -> err=1 with the macro, 0 without. Frame completes unchanged in both builds.

Source files
------------

// File: rtl/conv4_window_feeder_if.sv
// Stream-in / row-vector-out bundle between the upstream word source, the window feeder and the conv engine.
// Latency: none (wires only).
// Backpressure: s_valid/s_ready on the stream side; the engine side has no backpressure.
interface conv4_window_feeder_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 4,
    parameter int IMG_W       = 12,
    parameter int IMG_H       = 12
);
    logic [DATA_WIDTH-1:0]                    s_data;
    logic                                     s_valid;
    logic                                     s_ready;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]   conv_data;
    logic                                     conv_kload;
    logic                                     conv_valid_in;
    logic                                     conv_valid_out;
    logic [$clog2(IMG_H)-1:0]                 win_row;
    logic [$clog2(IMG_W)-1:0]                 win_col;

    // Word source / engine side.
    modport master (
        output s_data, s_valid,
        input  s_ready, conv_data, conv_kload, conv_valid_in, conv_valid_out, win_row, win_col
    );

    // Feeder side.
    modport slave (
        input  s_data, s_valid,
        output s_ready, conv_data, conv_kload, conv_valid_in, conv_valid_out, win_row, win_col
    );
endinterface

// File: rtl/conv4_window_feeder.sv
// Feeds a KxK conv engine: kernel rows, then vertical strips of a banked feature map plus a flush row.
// Latency: kernel row out 1 cycle after its last word; scan feeds 2 cycles after the image's last word.
// Backpressure: s_ready only in KLOAD/ILOAD, stalls just pause; optional overrun flag CONV4_FEEDER_OVERRUN_CHK_EN.
module conv4_window_feeder #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 4,
    parameter int IMG_W       = 12,
    parameter int IMG_H       = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    conv4_window_feeder_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int K     = KERNEL_SIZE;
    localparam int WB    = (IMG_W + K - 1) / K;   // words per map row in one bank
    localparam int DEPTH = IMG_H * WB;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int NW    = $clog2(IMG_H + 2);
    localparam int KW    = $clog2(K * K);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] KLOAD = 3'd1;
    localparam logic [2:0] ILOAD = 3'd2;
    localparam logic [2:0] SCAN  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]                        state;
    logic                              accept;
    logic [KW-1:0]                     kcnt, kcol;
    logic [K-1:0][DATA_WIDTH-1:0]      krow, kout;
    logic                              kpulse;
    logic [CW-1:0]                     px;
    logic [RW-1:0]                     py;
    logic                              img_last;
    logic [AW-1:0]                     wr_addr;
    logic [DATA_WIDTH-1:0]             mem [K][DEPTH];
    logic                              iss_act, iss_flush;
    logic [CW-1:0]                     ic;
    logic [NW-1:0]                     in_n;
    logic [AW-1:0]                     rd_addr [K];
    logic [DATA_WIDTH-1:0]             rd_q [K];
    logic                              s1_vld, s1_flush;
    logic [CW-1:0]                     s1_c;
    logic [NW-1:0]                     s1_n;
    logic [K-1:0][DATA_WIDTH-1:0]      rot;
    logic                              vo_q;
    logic [RW-1:0]                     win_row_q;
    logic [CW-1:0]                     win_col_q;

    assign bus.s_ready = (state == KLOAD) || (state == ILOAD);
    assign accept      = bus.s_valid && bus.s_ready;
    assign kcol        = kcnt % KW'(K);
    assign img_last    = (px == CW'(IMG_W - 1)) && (py == RW'(IMG_H - 1));
    assign iss_flush   = (in_n == NW'(IMG_H + 1));
    assign wr_addr     = AW'(int'(py) * WB + int'(px) / K);

    // Frame sequencing; the frame ends once the result tagged with the last window has been flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= KLOAD;
                KLOAD:   if (accept && kcnt == KW'(K * K - 1)) state <= ILOAD;
                ILOAD:   if (accept && img_last) state <= SCAN;
                SCAN:    if (vo_q && win_row_q == RW'(IMG_H - K) && win_col_q == CW'(IMG_W - K)) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Kernel words gather into a row; a completed row is presented for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            kcnt   <= '0;
            krow   <= '0;
            kout   <= '0;
            kpulse <= 1'b0;
        end else begin
            kpulse <= 1'b0;
            if (state == IDLE) begin
                kcnt <= '0;
            end else if (state == KLOAD && accept) begin
                kcnt <= kcnt + 1'b1;
                for (int j = 0; j < K; j++) begin
                    if (kcol == KW'(j)) krow[j] <= bus.s_data;
                end
                if (kcol == KW'(K - 1)) begin
                    kout        <= krow;
                    kout[K-1]   <= bus.s_data;
                    kpulse      <= 1'b1;
                end
            end
        end
    end

    // Raster position of the next incoming pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            px <= '0;
            py <= '0;
        end else if (state == IDLE) begin
            px <= '0;
            py <= '0;
        end else if (state == ILOAD && accept) begin
            if (px == CW'(IMG_W - 1)) begin
                px <= '0;
                py <= py + 1'b1;
            end else begin
                px <= px + 1'b1;
            end
        end
    end

    // Column-interleaved banks: any K adjacent columns land in K distinct banks.
    always_ff @(posedge clk) begin
        for (int b = 0; b < K; b++) begin
            if (state == ILOAD && accept && int'(px) % K == b) mem[b][wr_addr] <= bus.s_data;
        end
    end

    // Bank b holds the one strip column c+j with (c+j)%K == b.
    always_comb begin
        for (int b = 0; b < K; b++) begin
            rd_addr[b] = AW'((int'(in_n) - 1) * WB + (int'(ic) + ((b - int'(ic) % K + K) % K)) / K);
        end
    end

    // Registered bank read for the feed being issued; skipped on the flush feed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < K; b++) rd_q[b] <= '0;
        end else if (state == SCAN && iss_act && !iss_flush) begin
            for (int b = 0; b < K; b++) rd_q[b] <= mem[b][rd_addr[b]];
        end
    end

    // Issue walk over strips and feeds, back-to-back with no idle cycles between strips.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_act  <= 1'b0;
            ic       <= '0;
            in_n     <= '0;
            s1_vld   <= 1'b0;
            s1_flush <= 1'b0;
            s1_c     <= '0;
            s1_n     <= '0;
        end else begin
            s1_vld <= 1'b0;
            if (state == ILOAD && accept && img_last) begin
                iss_act <= 1'b1;
                ic      <= '0;
                in_n    <= NW'(1);
            end else if (state == SCAN && iss_act) begin
                s1_vld   <= 1'b1;
                s1_flush <= iss_flush;
                s1_c     <= ic;
                s1_n     <= in_n;
                if (iss_flush) begin
                    in_n <= NW'(1);
                    if (ic == CW'(IMG_W - K)) iss_act <= 1'b0;
                    else                      ic      <= ic + 1'b1;
                end else begin
                    in_n <= in_n + 1'b1;
                end
            end
        end
    end

    // Undo the bank interleave so that lane 0 is the strip's leftmost column.
    always_comb begin
        for (int j = 0; j < K; j++) begin
            rot[j] = '0;
            for (int b = 0; b < K; b++) begin
                if ((int'(s1_c) + j) % K == b) rot[j] = rd_q[b];
            end
        end
    end

    // A full window exists once K rows have been shifted in; the engine latches one cycle after that feed.
    always_ff @(posedge clk) begin
        if (rst) begin
            vo_q      <= 1'b0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            vo_q <= s1_vld && (s1_n >= NW'(K + 1));
            if (s1_vld && (s1_n >= NW'(K + 1))) begin
                win_row_q <= RW'(s1_n - NW'(K + 1));
                win_col_q <= s1_c;
            end
        end
    end

    assign bus.conv_data      = s1_vld ? (s1_flush ? '0 : rot) : kout;
    assign bus.conv_kload     = kpulse;
    assign bus.conv_valid_in  = kpulse || s1_vld;
    assign bus.conv_valid_out = vo_q;
    assign bus.win_row        = win_row_q;
    assign bus.win_col        = win_col_q;
    assign busy               = (state != IDLE);
    assign done               = (state == DONE);

`ifdef CONV4_FEEDER_OVERRUN_CHK_EN
    // Sticky record of a start request that arrived while a frame was in flight.
    always_ff @(posedge clk) begin
        if (rst)                err <= 1'b0;
        else if (start && busy) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_conv4_window_feeder.sv
// Bench for conv4_window_feeder: random and patterned frames against a queue-based reference of expected vectors.
// Latency: n/a.
// Backpressure: drives s_valid continuously or with a bubble before every word.
module tb_conv4_window_feeder;
    localparam int DW = 16;
    localparam int K  = 4;
    localparam int W  = 12;
    localparam int H  = 12;
    localparam int NFEED = (W - K + 1) * (H + 1);
    localparam int NVO   = (W - K + 1) * (H - K + 1);

`ifdef CONV4_FEEDER_OVERRUN_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, busy, done, err;

    conv4_window_feeder_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMG_W(W), .IMG_H(H)) bus ();

    conv4_window_feeder #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus.slave),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic                   kl;
        logic [K-1:0][DW-1:0]   dat;
        int                     c;
        int                     n;
    } feed_t;

    feed_t          exp_q[$];
    logic [DW-1:0]  kern [K*K];
    logic [DW-1:0]  img  [W*H];

    // Monitor state
    bit             mon_en = 0;
    int             cyc = 0;
    int             feeds, kloads, vos, dones, ready_cyc;
    int             last_feed_cyc, last_vo_cyc, last_row, last_col, cur_c;
    bit             pend_vo;
    int             pend_row, pend_col;
    logic [63:0]    cap_vec;
    feed_t          e;
    bit             exp_vo_now;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_vo_now = pend_vo;
            pend_vo    = 0;
            check("valid_out", bus.conv_valid_out, exp_vo_now);
            if (bus.conv_valid_out && exp_vo_now) begin
                check("win_row", bus.win_row, pend_row);
                check("win_col", bus.win_col, pend_col);
                vos++;
                last_vo_cyc = cyc;
                last_row    = pend_row;
                last_col    = pend_col;
            end
            if (bus.s_ready) ready_cyc++;
            if (bus.conv_valid_in) begin
                if (exp_q.size() == 0) begin
                    check("extra_feed", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("kload", bus.conv_kload, e.kl);
                    check("vector", bus.conv_data, e.dat);
                    if (e.kl) begin
                        kloads++;
                    end else begin
                        feeds++;
                        cur_c = e.c;
                        if (!(e.c == 0 && e.n == 1)) check("no_bubble", cyc - last_feed_cyc, 1);
                        last_feed_cyc = cyc;
                        if (e.c == 2 && e.n == 4) cap_vec = bus.conv_data;
                        if (e.n >= K + 1) begin
                            pend_vo  = 1;
                            pend_row = e.n - K - 1;
                            pend_col = e.c;
                        end
                    end
                end
            end
            if (done) begin
                dones++;
                check("done_delay", cyc - last_vo_cyc, 1);
            end
        end
    end

    // Reference: kernel rows, then per strip c the rows y=0..H-1 of columns c..c+K-1, then a zero row.
    task automatic build_model();
        feed_t f;
        exp_q.delete();
        for (int r = 0; r < K; r++) begin
            f.kl = 1; f.c = -1; f.n = -1;
            for (int j = 0; j < K; j++) f.dat[j] = kern[r*K + j];
            exp_q.push_back(f);
        end
        for (int c = 0; c <= W - K; c++) begin
            for (int n = 1; n <= H + 1; n++) begin
                f.kl = 0; f.c = c; f.n = n;
                for (int j = 0; j < K; j++) f.dat[j] = (n <= H) ? img[(n-1)*W + c + j] : '0;
                exp_q.push_back(f);
            end
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit gap);
        int g;
        if (gap) begin
            bus.s_valid = 0;
            @(posedge clk); #1;
        end
        bus.s_valid = 1;
        bus.s_data  = w;
        g = 0;
        while (!bus.s_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 50) check("s_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // mode 0: all 1.0; mode 1: pixel y*16+x with random kernel; mode 2: fully random
    task automatic start_frame(input int mode, input bit gap, input bit mid_start);
        for (int i = 0; i < K*K; i++) kern[i] = (mode == 0) ? 16'h3C00 : 16'($urandom);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y*W + x] = (mode == 0) ? 16'h3C00 : (mode == 1) ? 16'(y*16 + x) : 16'($urandom);
        build_model();
        feeds = 0; kloads = 0; vos = 0; dones = 0; ready_cyc = 0;
        last_feed_cyc = 0; last_vo_cyc = 0; last_row = -1; last_col = -1; cur_c = -1;
        pend_vo = 0; cap_vec = '0;
        mon_en = 1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < K*K; i++) send_word(kern[i], gap);
        for (int i = 0; i < W*H; i++) begin
            if (mid_start && i == 50) start = 1;
            send_word(img[i], gap);
            start = 0;
        end
        bus.s_valid = 0;
    endtask

    task automatic finish_frame(input int mode, input bit gap, input bit start_in_done);
        int g = 0;
        logic [63:0] want = 64'h0035_0034_0033_0032;
        while (!done && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        check("done_seen", done, 1);
        if (start_in_done) start = 1;
        @(posedge clk); #1;
        start = 0;
        check("idle_after_done", busy, 0);
        check("no_ready_after_done", bus.s_ready, 0);
        @(posedge clk); #1;
        check("start_in_done_ignored", busy, 0);
        check("feeds", feeds, NFEED);
        check("kloads", kloads, K);
        check("valid_outs", vos, NVO);
        check("done_pulses", dones, 1);
        check("model_drained", exp_q.size(), 0);
        check("last_row", last_row, H - K);
        check("last_col", last_col, W - K);
        check("win_row_hold", bus.win_row, H - K);
        check("win_col_hold", bus.win_col, W - K);
        check("load_cycles", ready_cyc, gap ? 2*(K*K + W*H) : (K*K + W*H));
        if (mode == 1) check("strip2_feed4", cap_vec, want);
        mon_en = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, bus.s_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_valid_in"}, bus.conv_valid_in, 0);
        check({tag, "_valid_out"}, bus.conv_valid_out, 0);
        check({tag, "_kload"}, bus.conv_kload, 0);
        check({tag, "_data"}, bus.conv_data, 0);
        check({tag, "_win_row"}, bus.win_row, 0);
        check({tag, "_win_col"}, bus.win_col, 0);
    endtask

    initial begin
        int g;
        int done_cnt;
        rst = 1; start = 0;
        bus.s_valid = 0; bus.s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 0;
        @(posedge clk); #1;

        // All-ones frame, with a start pulse in the DONE cycle that must be ignored
        start_frame(0, 0, 0);
        finish_frame(0, 0, 1);
        check("err_after_done_start", err, ERR_EXP);

        // Positional pixels
        start_frame(1, 0, 0);
        finish_frame(1, 0, 0);

        // Bubbled stream
        start_frame(0, 1, 0);
        finish_frame(0, 1, 0);
        start_frame(2, 1, 0);
        finish_frame(2, 1, 0);

        // Extra start during ILOAD
        start_frame(2, 0, 1);
        check("err_mid_iload", err, ERR_EXP);
        finish_frame(2, 0, 0);
        check("err_sticky", err, ERR_EXP);

        // Abort in strip 4
        start_frame(2, 0, 0);
        g = 0;
        while (cur_c < 4 && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        check("reached_strip4", cur_c, 4);
        mon_en = 0;
        rst = 1;
        @(posedge clk); #1;
        check_all_zero("abort");
        rst = 0;
        done_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("no_done_after_abort", done_cnt, 0);
        check("idle_after_abort", busy, 0);

        // Fresh frame after abort
        start_frame(0, 0, 0);
        finish_frame(0, 0, 0);
        start_frame(1, 0, 0);
        finish_frame(1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
